// File: rtl/mem_align_unit.sv
// mem_align_unit: byte/half/word load-store front end for a word-organised memory port.
// Word-straddling accesses are split into two beats; loads are merged, shifted and extended.
module mem_align_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wes,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBeat0 = 2'd1;
    localparam logic [1:0] StBeat1 = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [31:0]           wdata_q;
    logic [31:0]           low_q;
    logic [ADDR_WIDTH-3:0] mem_addr_q;

    logic [1:0]            off;
    logic [2:0]            nbytes;
    logic [3:0]            mask4;
    logic                  split;
    logic [7:0]            m8;
    logic [63:0]           w64;
    logic [63:0]           r64;
    logic [31:0]           field;
    logic [ADDR_WIDTH-3:0] word_addr;

    // Decode the latched request: lane mask, shifted store data, split detection.
    always_comb begin
        off       = addr_q[1:0];
        word_addr = addr_q[ADDR_WIDTH-1:2];
        nbytes    = 3'd4;
        mask4     = 4'b1111;
        unique case (size_q)
            2'b00:   begin nbytes = 3'd1; mask4 = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; mask4 = 4'b0011; end
            default: begin nbytes = 3'd4; mask4 = 4'b1111; end
        endcase
        split = ({1'b0, off} + nbytes) > 3'd4;
        m8    = {4'b0000, mask4} << off;
        w64   = {32'b0, wdata_q} << {off, 3'b000};
    end

    // Load merge: the low word comes from the first beat when the access was split.
    always_comb begin
        r64   = split ? {mem_rdata, low_q} : {32'b0, mem_rdata};
        field = r64[{off, 3'b000} +: 32];
    end

    // Next-state logic for the beat sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = StBeat0;
            StBeat0: state_d = split ? StBeat1 : StResp;
            StBeat1: state_d = StResp;
            default: state_d = StIdle;
        endcase
    end

    // State register; reset abandons any in-flight access including a pending second beat.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Capture the request on accept; held stable until the unit is idle again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else if (state_q == StIdle && req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
        end
    end

    // Hold the first-beat read word while the second beat's read is in flight.
    always_ff @(posedge clk) begin
        if (!rst)                    low_q <= '0;
        else if (state_q == StBeat1) low_q <= mem_rdata;
    end

    // mem_addr keeps its last driven value between accesses.
    always_ff @(posedge clk) begin
        if (!rst) mem_addr_q <= '0;
        else      mem_addr_q <= mem_addr;
    end

    // Output decode; every output is forced quiet while reset is asserted.
    always_comb begin
        req_ready  = rst && (state_q == StIdle);
        resp_valid = 1'b0;
        resp_rdata = '0;
        mem_addr   = mem_addr_q;
        mem_wes    = 4'b0000;
        mem_wdata  = '0;
        if (!rst) begin
            mem_addr = '0;
        end else begin
            unique case (state_q)
                StBeat0: begin
                    mem_addr = word_addr;
                    if (we_q) begin
                        mem_wes   = m8[3:0];
                        mem_wdata = w64[31:0];
                    end
                end
                StBeat1: begin
                    mem_addr = word_addr + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
                    if (we_q) begin
                        mem_wes   = m8[7:4];
                        mem_wdata = w64[63:32];
                    end
                end
                StResp: begin
                    resp_valid = 1'b1;
                    if (!we_q) begin
                        unique case (size_q)
                            2'b00:   resp_rdata = uns_q ? {24'b0, field[7:0]}
                                                        : {{24{field[7]}}, field[7:0]};
                            2'b01:   resp_rdata = uns_q ? {16'b0, field[15:0]}
                                                        : {{16{field[15]}}, field[15:0]};
                            default: resp_rdata = field;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
